stack_ctrl: RTL

- Initiator-side controller for the RAM-backed data/return stack.
- Accepts a valid/ready command stream (PUSH, POP, PEEK, REPLACE) from the core sequencer.
- Converts each command into the stack's delta/we/wd interface and consumes the stack's rd output.
- Keeps a registered top-of-stack (TOS) copy, a depth counter, overflow/underflow flags, and a drain engine for runtime clear.

---
 rtl/stack_pkg.sv | 22 ++
 rtl/stack_depth_cnt.sv | 71 +++++++
 rtl/stack_ctrl.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/stack_pkg.sv
// Shared definitions for the stack controller slice: command opcodes,
// stack delta encodings and the controller FSM state type.
package stack_pkg;

    // Command opcodes on cmd_op
    localparam logic [1:0] OP_PEEK    = 2'b00;
    localparam logic [1:0] OP_PUSH    = 2'b01;
    localparam logic [1:0] OP_REPLACE = 2'b10;
    localparam logic [1:0] OP_POP     = 2'b11;

    // Pointer movement requests toward the stack RAM
    localparam logic [1:0] DELTA_HOLD = 2'b00;
    localparam logic [1:0] DELTA_PUSH = 2'b01;
    localparam logic [1:0] DELTA_POP  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REFILL = 2'd1,
        ST_DRAIN  = 2'd2
    } state_t;

endpackage

// File: rtl/stack_depth_cnt.sv
// Up/down depth counter for the stack controller. Decides on its own
// whether a push/pop request may move the count, and raises the sticky
// overflow/underflow flags when it may not.
// Optional: STACK_CTRL_WATERMARK_EN adds hi_water, the highest depth
// reached since reset or the last flag clear.
module stack_depth_cnt #(
    parameter int DEPTH     = 512,
    parameter int CNT_WIDTH = $clog2(DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inc_req,
    input  logic                 dec_req,
    input  logic                 chk_req,
    input  logic                 clr_flags,
`ifdef STACK_CTRL_WATERMARK_EN
    output logic [CNT_WIDTH-1:0] hi_water,
`endif
    output logic [CNT_WIDTH-1:0] depth,
    output logic                 full,
    output logic                 empty,
    output logic                 ovf,
    output logic                 unf
);

    logic [CNT_WIDTH-1:0] depth_inc;

    assign full      = (depth == CNT_WIDTH'(DEPTH));
    assign empty     = (depth == '0);
    assign depth_inc = depth + CNT_WIDTH'(1);

    // Count moves only when the request is legal; illegal requests only flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            depth <= '0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else begin
            if (clr_flags) begin
                ovf <= 1'b0;
                unf <= 1'b0;
            end else begin
                if (inc_req && full) begin
                    ovf <= 1'b1;
                end
                if ((dec_req || chk_req) && empty) begin
                    unf <= 1'b1;
                end
            end
            if (inc_req && !full) begin
                depth <= depth_inc;
            end else if (dec_req && !empty) begin
                depth <= depth - CNT_WIDTH'(1);
            end
        end
    end

`ifdef STACK_CTRL_WATERMARK_EN
    // Track the peak depth; only growth can raise it, a clear restarts it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_water <= '0;
        end else if (clr_flags) begin
            hi_water <= '0;
        end else if (inc_req && !full && (depth_inc > hi_water)) begin
            hi_water <= depth_inc;
        end
    end
`endif

endmodule

// File: rtl/stack_ctrl.sv
// Initiator-side controller for the RAM-backed stack. Turns a valid/ready
// command stream into delta/we/wd requests, keeps a registered TOS copy,
// refills it after pops and drains the stack on a runtime clr.
// Optional: STACK_CTRL_WATERMARK_EN exposes the hi_water peak-depth port.
module stack_ctrl #(
    parameter int WIDTH     = 16,
    parameter int DEPTH     = 512,
    parameter int CNT_WIDTH = $clog2(DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [1:0]           cmd_op,
    input  logic [WIDTH-1:0]     cmd_data,
    output logic                 rsp_valid,
    output logic [WIDTH-1:0]     rsp_data,
    output logic                 rsp_err,
    output logic [CNT_WIDTH-1:0] depth,
    output logic                 full,
    output logic                 empty,
    output logic                 ovf,
    output logic                 unf,
`ifdef STACK_CTRL_WATERMARK_EN
    output logic [CNT_WIDTH-1:0] hi_water,
`endif
    output logic [1:0]           stk_delta,
    output logic                 stk_we,
    output logic [WIDTH-1:0]     stk_wd,
    input  logic [WIDTH-1:0]     stk_rd
);

    import stack_pkg::*;

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] tos_q;
    logic             accept;
    logic             inc_req;
    logic             dec_req;
    logic             chk_req;
    logic             clr_flags;
    logic             last_entry;

    assign last_entry = (depth == CNT_WIDTH'(1));

    stack_depth_cnt #(
        .DEPTH     (DEPTH),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_depth_cnt (
        .clk       (clk),
        .rst       (rst),
        .inc_req   (inc_req),
        .dec_req   (dec_req),
        .chk_req   (chk_req),
        .clr_flags (clr_flags),
`ifdef STACK_CTRL_WATERMARK_EN
        .hi_water  (hi_water),
`endif
        .depth     (depth),
        .full      (full),
        .empty     (empty),
        .ovf       (ovf),
        .unf       (unf)
    );

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state plus the combinational stack requests for this cycle
    always_comb begin
        next_state = state;
        cmd_ready  = 1'b0;
        accept     = 1'b0;
        stk_delta  = DELTA_HOLD;
        stk_we     = 1'b0;
        stk_wd     = cmd_data;
        inc_req    = 1'b0;
        dec_req    = 1'b0;
        chk_req    = 1'b0;
        clr_flags  = 1'b0;
        case (state)
            ST_IDLE: begin
                cmd_ready = !clr;
                if (clr) begin
                    clr_flags = 1'b1;
                    if (!empty) begin
                        next_state = ST_DRAIN;
                    end
                end else if (cmd_valid) begin
                    accept = 1'b1;
                    case (cmd_op)
                        OP_PUSH: begin
                            inc_req = 1'b1;
                            if (!full) begin
                                stk_delta = DELTA_PUSH;
                                stk_we    = 1'b1;
                            end
                        end
                        OP_REPLACE: begin
                            chk_req = 1'b1;
                            stk_we  = !empty;
                        end
                        OP_POP: begin
                            dec_req = 1'b1;
                            if (!empty) begin
                                stk_delta = DELTA_POP;
                                if (!last_entry) begin
                                    next_state = ST_REFILL;
                                end
                            end
                        end
                        default: begin
                            chk_req = 1'b1;
                        end
                    endcase
                end
            end
            ST_REFILL: begin
                if (clr) begin
                    clr_flags  = 1'b1;
                    next_state = ST_DRAIN;
                end else begin
                    next_state = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (empty) begin
                    next_state = ST_IDLE;
                end else begin
                    stk_delta = DELTA_POP;
                    dec_req   = 1'b1;
                    if (last_entry) begin
                        next_state = ST_IDLE;
                    end
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // TOS copy and one-cycle response generation
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tos_q     <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            if (state == ST_REFILL) begin
                tos_q <= stk_rd;
            end
            if ((state == ST_DRAIN) && (last_entry || empty)) begin
                tos_q <= '0;
            end
            if (accept) begin
                case (cmd_op)
                    OP_PUSH: begin
                        if (!full) begin
                            tos_q <= cmd_data;
                        end
                    end
                    OP_REPLACE: begin
                        if (!empty) begin
                            tos_q <= cmd_data;
                        end else begin
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_data  <= '0;
                        end
                    end
                    default: begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= empty;
                        rsp_data  <= empty ? '0 : tos_q;
                    end
                endcase
            end
        end
    end

endmodule
